// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default widths for the countdown timer
package timer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PS_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable tick divider, one tick every prescale+1 enabled cycles
module tick_prescaler #(
  parameter int PS_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [PS_W-1:0] prescale,
  output logic            tick
);

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;

  // >= rather than == so that shrinking prescale mid-count fires at once instead of wrapping
  always_comb begin
    tick = enable && (ps_q >= prescale);
    ps_d = ps_q;
    if (clear) begin
      ps_d = '0;
    end else if (enable) begin
      ps_d = tick ? '0 : ps_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule

// File: rtl/countdown_timer_8bit.sv
// rtl/countdown_timer_8bit.sv - loadable down-counting timer with one-shot and periodic modes
module countdown_timer_8bit
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PS_W  = DEF_PS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [PS_W-1:0]  prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             ps_clear;
  logic             tick;

  tick_prescaler #(
    .PS_W(PS_W)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ps_clear),
    .enable  (state_q == ST_RUN),
    .prescale(prescale),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    tc_d     = 1'b0;
    ps_clear = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      done_d   = 1'b0;
      state_d  = ST_IDLE;
      ps_clear = 1'b1;
    end else if (stop) begin
      // stop also masks a same-cycle start when idle
      if (state_q == ST_RUN) begin
        state_d  = ST_IDLE;
        ps_clear = 1'b1;
      end
    end else if (start && (state_q != ST_RUN)) begin
      done_d   = 1'b0;
      ps_clear = 1'b1;
      if (count_q != '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        tc_d    = 1'b1;
      end
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (periodic) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign count    = count_q;
  assign busy     = busy_q;
  assign tc_pulse = tc_q;
  assign done     = done_q;

endmodule
